// File: rtl/serial_det_arb_pkg.sv
// Shared types and helpers for the serial detector arbiter.
// Optional hit counter is enabled with the HIT_COUNT_EN macro.
package serial_det_arb_pkg;

  localparam int MAX_NREQ = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FLUSH   = 2'b01,
    STREAM  = 2'b10,
    RELEASE = 2'b11
  } arb_state_e;

  function automatic logic [MAX_NREQ-1:0] onehot(input int idx);
    return MAX_NREQ'(1) << idx;
  endfunction

  // Next index in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/serial_det_arbiter_if.sv
// Requester/detector bus of the serial detector arbiter.
// HIT_COUNT_EN adds the per-grant hit counter (hit_cnt, width HC_W).
interface serial_det_arbiter_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
`ifdef HIT_COUNT_EN
  , parameter int HC_W = 4
`endif
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] ser_in;
  logic [NREQ-1:0] grant;
  logic            det_rst;
  logic            det_serin;
  logic            det_out;
  logic            hit_valid;
  logic [ID_W-1:0] hit_id;
  logic            burst_done;
`ifdef HIT_COUNT_EN
  logic [HC_W-1:0] hit_cnt;

  modport master (
    input  req, ser_in, det_out,
    output grant, det_rst, det_serin, hit_valid, hit_id, burst_done, hit_cnt
  );
  modport slave (
    output req, ser_in, det_out,
    input  grant, det_rst, det_serin, hit_valid, hit_id, burst_done, hit_cnt
  );
`else
  modport master (
    input  req, ser_in, det_out,
    output grant, det_rst, det_serin, hit_valid, hit_id, burst_done
  );
  modport slave (
    output req, ser_in, det_out,
    input  grant, det_rst, det_serin, hit_valid, hit_id, burst_done
  );
`endif
endinterface

// File: rtl/serial_det_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_ptr, wrapping,
// so the previous owner has the lowest priority.
module rr_pick
  import serial_det_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last_ptr,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  logic [ID_W-1:0] cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = last_ptr;
    for (int i = 0; i < NREQ; i++) begin
      cand = ID_W'(wrap_inc(int'(cand), NREQ));
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/serial_det_arbiter.sv
// Round-robin sequencer sharing one serial "sequence detector" among NREQ sources.
// Define HIT_COUNT_EN to add the saturating per-grant hit counter (bus.hit_cnt).
module serial_det_arbiter
  import serial_det_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int BURST_LEN = 8,
  parameter int ID_W      = 2
) (
  input logic                 clk,
  input logic                 rst,
  serial_det_arbiter_if.master bus
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] last_ptr_q, last_ptr_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [ID_W-1:0] pick_idx;
  logic            pick_any;
  logic            det_window;

  rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .req      (bus.req),
    .last_ptr (last_ptr_q),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_ptr_q <= ID_W'(NREQ - 1);
      bit_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_ptr_q <= last_ptr_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  // NOTE: every variable gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_ptr_d = last_ptr_q;
    bit_cnt_d  = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        bit_cnt_d = '0;
        state_d   = STREAM;
      end
      STREAM: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == CNT_W'(BURST_LEN - 1) || !bus.req[owner_q])
          state_d = RELEASE;
      end
      RELEASE: begin
        last_ptr_d = owner_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.grant      = '0;
    bus.det_serin  = 1'b0;
    bus.burst_done = 1'b0;
    det_window     = 1'b0;
    case (state_q)
      FLUSH: bus.grant = NREQ'(onehot(int'(owner_q)));
      STREAM: begin
        bus.grant     = NREQ'(onehot(int'(owner_q)));
        bus.det_serin = bus.ser_in[owner_q];
        det_window    = 1'b1;
      end
      RELEASE: begin
        bus.grant      = NREQ'(onehot(int'(owner_q)));
        bus.burst_done = 1'b1;
        det_window     = 1'b1;
      end
      default: ;
    endcase
  end

  // The detector is held flushed for as long as the arbiter itself is in reset.
  assign bus.det_rst   = !rst || (state_q == FLUSH);
  assign bus.hit_valid = bus.det_out & det_window;
  assign bus.hit_id    = owner_q;

`ifdef HIT_COUNT_EN
  localparam int HC_W = $clog2(BURST_LEN + 1);

  logic [HC_W-1:0] hit_cnt_q, hit_cnt_inc;

  assign hit_cnt_inc = (bus.hit_valid && hit_cnt_q != HC_W'(BURST_LEN))
                     ? hit_cnt_q + 1'b1 : hit_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  hit_cnt_q <= '0;
    else if (state_q == FLUSH) hit_cnt_q <= '0;
    else                       hit_cnt_q <= hit_cnt_inc;
  end

  // A hit seen during RELEASE is already included while burst_done is high.
  assign bus.hit_cnt = (state_q == RELEASE) ? hit_cnt_inc : hit_cnt_q;
`endif

endmodule

// File: tb/tb_serial_det_arbiter.sv
// Directed bench for serial_det_arbiter with a behavioural overlapping "101" detector.
module tb_serial_det_arbiter;

  localparam int NREQ      = 4;
  localparam int BURST_LEN = 8;
  localparam int ID_W      = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] hist = 3'b000;
  int         checks = 0;
  int         errors = 0;

  logic [7:0] pat;
  logic [7:0] hits;
  logic [3:0] exp_g;

  serial_det_arbiter_if #(
    .NREQ(NREQ), .ID_W(ID_W)
`ifdef HIT_COUNT_EN
    , .HC_W(4)
`endif
  ) bus ();

  serial_det_arbiter #(.NREQ(NREQ), .BURST_LEN(BURST_LEN), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Overlapping "101" detector, Moore output, synchronous active-high flush.
  always @(posedge clk) begin
    if (bus.det_rst) hist <= 3'b000;
    else             hist <= {hist[1:0], bus.det_serin};
  end
  assign bus.det_out = (hist == 3'b101);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req    = '0;
    bus.ser_in = '0;

    // Reset values, then idle with no requests
    repeat (3) tick();
    chk("rst_grant", bus.grant, 4'b0000);
    chk("rst_det_rst", bus.det_rst, 1'b1);
    chk("rst_det_serin", bus.det_serin, 1'b0);
    chk("rst_hit_valid", bus.hit_valid, 1'b0);
    chk("rst_hit_id", bus.hit_id, 2'd0);
    chk("rst_burst_done", bus.burst_done, 1'b0);
    rst = 1'b1;
    #1;
    chk("idle_det_rst", bus.det_rst, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_hit_valid", bus.hit_valid, 1'b0);
      chk("idle_grant", bus.grant, 4'b0000);
    end

    // Source 0 streams 1,0,1,0,1,0,0,0 -> hits in stream cycles 3 and 5
    bus.req = 4'b0001;
    #1;
    chk("t2_pre_grant", bus.grant, 4'b0000);
    tick();
    chk("t2_flush_grant", bus.grant, 4'b0001);
    chk("t2_flush_det_rst", bus.det_rst, 1'b1);
    chk("t2_flush_det_serin", bus.det_serin, 1'b0);
    pat  = 8'b0001_0101;
    hits = 8'b0010_1000;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.ser_in = {3'b000, pat[i]};
      #1;
      chk("t2_det_serin", bus.det_serin, pat[i]);
      chk("t2_grant", bus.grant, 4'b0001);
      chk("t2_det_rst", bus.det_rst, 1'b0);
      chk("t2_hit_valid", bus.hit_valid, hits[i]);
      chk("t2_hit_id", bus.hit_id, 2'd0);
      chk("t2_burst_done", bus.burst_done, 1'b0);
    end
    tick();
    bus.ser_in = 4'b1111;
    #1;
    chk("t2_rel_burst_done", bus.burst_done, 1'b1);
    chk("t2_rel_grant", bus.grant, 4'b0001);
    chk("t2_rel_det_serin", bus.det_serin, 1'b0);
    chk("t2_rel_hit_valid", bus.hit_valid, 1'b0);
    bus.ser_in = 4'b0000;
    tick();
    chk("t2_gap_grant", bus.grant, 4'b0000);
    chk("t2_gap_burst_done", bus.burst_done, 1'b0);
    tick();
    chk("t2_regrant", bus.grant, 4'b0001);
    bus.req = 4'b0000;
    tick();
    bus.ser_in = 4'b0001;
    #1;
    chk("t2_early_stream_grant", bus.grant, 4'b0001);
    chk("t2_early_det_serin", bus.det_serin, 1'b1);
    chk("t2_early_no_done", bus.burst_done, 1'b0);
    tick();
    bus.ser_in = 4'b0000;
    chk("t2_early_release", bus.burst_done, 1'b1);
    tick();
    chk("t2_early_idle", bus.grant, 4'b0000);

    // Rotation with all sources requesting, starting fresh from reset
    rst = 1'b0;
    #1;
    chk("t3_rst_grant", bus.grant, 4'b0000);
    tick();
    rst = 1'b1;
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << (g % 4);
      tick();
      chk("t3_flush_grant", bus.grant, exp_g);
      for (int c = 1; c < 10; c++) begin
        tick();
        chk("t3_grant", bus.grant, exp_g);
        chk("t3_burst_done", bus.burst_done, (c == 9) ? 1'b1 : 1'b0);
      end
      tick();
      chk("t3_gap", bus.grant, 4'b0000);
    end
    bus.req = 4'b0000;

    // Owner 2 streams "10" and drops req; owner 3 then streams 1,0,1,0,...
    bus.req = 4'b1100;
    tick();
    chk("t4_grant2", bus.grant, 4'b0100);
    tick();
    bus.ser_in = 4'b0100;
    #1;
    chk("t4_det_serin_b0", bus.det_serin, 1'b1);
    tick();
    bus.ser_in = 4'b0000;
    bus.req    = 4'b1000;
    #1;
    chk("t4_det_serin_b1", bus.det_serin, 1'b0);
    chk("t4_grant2_b1", bus.grant, 4'b0100);
    tick();
    chk("t4_early_done", bus.burst_done, 1'b1);
    chk("t4_rel_grant", bus.grant, 4'b0100);
    tick();
    chk("t4_gap", bus.grant, 4'b0000);
    tick();
    chk("t4_grant3", bus.grant, 4'b1000);
    pat  = 8'b0000_0101;
    hits = 8'b0000_1000;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.ser_in = {pat[i], 3'b000};
      #1;
      chk("t4_hit_valid", bus.hit_valid, hits[i]);
      chk("t4_hit_id", bus.hit_id, 2'd3);
      chk("t4_grant3_s", bus.grant, 4'b1000);
    end
    tick();
    bus.ser_in = 4'b0000;
    bus.req    = 4'b0000;
    chk("t4_rel_hit_valid", bus.hit_valid, 1'b0);
    chk("t4_rel_done", bus.burst_done, 1'b1);
    tick();
    chk("t4_idle", bus.grant, 4'b0000);

    // Reset in the middle of a burst
    bus.req    = 4'b0001;
    bus.ser_in = 4'b0001;
    tick();
    chk("t5_grant", bus.grant, 4'b0001);
    repeat (5) tick();
    chk("t5_stream_grant", bus.grant, 4'b0001);
    chk("t5_stream_serin", bus.det_serin, 1'b1);
    rst = 1'b0;
    #1;
    chk("t5_rst_grant", bus.grant, 4'b0000);
    chk("t5_rst_det_rst", bus.det_rst, 1'b1);
    chk("t5_rst_det_serin", bus.det_serin, 1'b0);
    chk("t5_rst_burst_done", bus.burst_done, 1'b0);
    chk("t5_rst_hit_id", bus.hit_id, 2'd0);
    tick();
    rst = 1'b1;
    bus.req    = 4'b1111;
    bus.ser_in = 4'b0000;
    tick();
    chk("t5_first_grant", bus.grant, 4'b0001);
    bus.req = 4'b0000;
    tick();
    tick();
    chk("t5_done", bus.burst_done, 1'b1);
    tick();
    chk("t5_idle", bus.grant, 4'b0000);

`ifdef HIT_COUNT_EN
    // Hit counter: 1,0,1,0,1,0,1,0 -> three hits in one grant
    bus.req = 4'b0001;
    tick();
    chk("t6_grant", bus.grant, 4'b0001);
    pat  = 8'b0101_0101;
    hits = 8'b1010_1000;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.ser_in = {3'b000, pat[i]};
      #1;
      chk("t6_hit_valid", bus.hit_valid, hits[i]);
    end
    tick();
    bus.req    = 4'b0000;
    bus.ser_in = 4'b0000;
    chk("t6_done", bus.burst_done, 1'b1);
    chk("t6_hit_cnt_done", bus.hit_cnt, 4'd3);
    tick();
    chk("t6_hit_cnt_held", bus.hit_cnt, 4'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
